// File: rtl/serial_mac_pkg.sv
`default_nettype none
// ============================================================================
// Module      : serial_mac_pkg
// Description : Shared types and constants for the bit-serial MAC sequencer.
//               Holds the FSM state encoding, default operand/accumulator
//               widths and the helper that sizes the pass/bit counters.
// Revision    : 1.0 - initial release
// ============================================================================
package serial_mac_pkg;

    localparam int DEF_WIDTH = 4;
    localparam int DEF_ACC_W = 12;

    // Counter width for a counter that runs 0..n-1; never narrower than 1 bit
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int DEF_CYC_W = cnt_w(DEF_ACC_W);
    localparam int DEF_BIT_W = cnt_w(DEF_WIDTH);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/full_adder.sv
`default_nettype none
// ============================================================================
// Module      : full_adder
// Description : 1-bit full adder cell.
//   i_a, i_b  : addend bits
//   i_cin     : carry in
//   o_sum     : sum bit
//   o_cout    : carry out
// Revision    : 1.0 - initial release
// ============================================================================
module full_adder (
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin,
    output logic o_sum,
    output logic o_cout
);

    assign o_sum  = i_a ^ i_b ^ i_cin;
    assign o_cout = (i_a & i_b) | (i_cin & (i_a ^ i_b));

endmodule
`default_nettype wire

// File: rtl/serial_mac_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : serial_mac_ctrl
// Description : Unsigned multiply-accumulate (acc += a*b) built on a single
//               time-shared 1-bit full adder. Each multiplier bit costs one
//               serial pass of ACC_W cycles; all passes run regardless of the
//               multiplier bit value, so latency is fixed.
//   clk, rst  : clock, asynchronous active-high reset
//   in_valid  : operand pair offered       in_ready : accepting (IDLE only)
//   a, b      : multiplicand / multiplier  clear    : zero acc + overflow
//   busy      : operation in progress      out_valid: acc_out just updated
//   acc_out   : registered accumulator     overflow : sticky pass carry-out
// Revision    : 1.0 - initial release
// ============================================================================
module serial_mac_ctrl
    import serial_mac_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int ACC_W = DEF_ACC_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             clear,
    output logic             busy,
    output logic             out_valid,
    output logic [ACC_W-1:0] acc_out,
    output logic             overflow
);

    localparam int c_CYC_W = cnt_w(ACC_W);
    localparam int c_BIT_W = cnt_w(WIDTH);

    generate
        if (ACC_W < 2 * WIDTH) begin : g_param_check
            $error("serial_mac_ctrl: ACC_W must be at least 2*WIDTH");
        end
    endgenerate

    state_t               r_state;
    state_t               w_state_next;
    logic [ACC_W-1:0]     r_acc;
    logic [ACC_W-1:0]     r_addend;
    logic [WIDTH-1:0]     r_mult;
    logic [c_CYC_W-1:0]   r_cyc;
    logic [c_BIT_W-1:0]   r_bit_idx;
    logic                 r_carry;
    logic                 r_overflow;
    logic [ACC_W-1:0]     r_acc_out;

    logic                 w_accept;
    logic                 w_last_cyc;
    logic                 w_last_pass;
    logic                 w_fa_b;
    logic                 w_sum;
    logic                 w_cout;
    logic [ACC_W-1:0]     w_acc_next;
    logic [ACC_W-1:0]     w_addend_rot;
    logic [ACC_W-1:0]     w_addend_shl;

    assign w_accept    = in_valid & in_ready;
    assign w_last_cyc  = (r_cyc == c_CYC_W'(ACC_W - 1));
    assign w_last_pass = (r_bit_idx == c_BIT_W'(WIDTH - 1));

    // Multiplier bit gates the addend: a zero bit turns the pass into acc+0
    assign w_fa_b = r_addend[0] & r_mult[r_bit_idx];

    full_adder u_fa (
        .i_a    (r_acc[0]),
        .i_b    (w_fa_b),
        .i_cin  (r_carry),
        .o_sum  (w_sum),
        .o_cout (w_cout)
    );

    assign w_acc_next   = {w_sum, r_acc[ACC_W-1:1]};
    assign w_addend_rot = {r_addend[0], r_addend[ACC_W-1:1]};
    // After a full rotation the addend is back in place; one extra left
    // shift weights it for the next multiplier bit
    assign w_addend_shl = {w_addend_rot[ACC_W-2:0], 1'b0};

    // ---------------------------------------------------------------- state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ----------------------------------------------------------- next state
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_state_next = ST_ADD;
            ST_ADD:  if (w_last_cyc && w_last_pass) w_state_next = ST_DONE;
            ST_DONE: w_state_next = ST_IDLE;
            default: w_state_next = ST_IDLE;
        endcase
    end

    // -------------------------------------------------------------- outputs
    always_comb begin
        in_ready  = 1'b0;
        busy      = 1'b0;
        out_valid = 1'b0;
        case (r_state)
            ST_IDLE: in_ready  = 1'b1;
            ST_ADD:  busy      = 1'b1;
            ST_DONE: begin
                busy      = 1'b1;
                out_valid = 1'b1;
            end
            default: in_ready = 1'b0;
        endcase
    end

    // ------------------------------------------------------------- datapath
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_acc      <= '0;
            r_addend   <= '0;
            r_mult     <= '0;
            r_cyc      <= '0;
            r_bit_idx  <= '0;
            r_carry    <= 1'b0;
            r_overflow <= 1'b0;
            r_acc_out  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    // clear takes effect before a same-cycle capture, so the
                    // new operation accumulates onto zero
                    if (clear) begin
                        r_acc      <= '0;
                        r_acc_out  <= '0;
                        r_overflow <= 1'b0;
                    end
                    if (w_accept) begin
                        r_addend  <= {{(ACC_W - WIDTH){1'b0}}, a};
                        r_mult    <= b;
                        r_cyc     <= '0;
                        r_bit_idx <= '0;
                        r_carry   <= 1'b0;
                    end
                end
                ST_ADD: begin
                    r_acc <= w_acc_next;
                    if (w_last_cyc) begin
                        r_overflow <= r_overflow | w_cout;
                        r_carry    <= 1'b0;
                        r_cyc      <= '0;
                        r_addend   <= w_addend_shl;
                        r_bit_idx  <= r_bit_idx + c_BIT_W'(1);
                        // Publish the final sum on the edge entering DONE so
                        // acc_out is already valid while out_valid is high
                        if (w_last_pass) begin
                            r_acc_out <= w_acc_next;
                        end
                    end else begin
                        r_carry  <= w_cout;
                        r_cyc    <= r_cyc + c_CYC_W'(1);
                        r_addend <= w_addend_rot;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign acc_out  = r_acc_out;
    assign overflow = r_overflow;

endmodule
`default_nettype wire

// File: tb/tb_serial_mac_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_mac_ctrl
// Description : Self-checking bench for serial_mac_ctrl. A reference model
//               tracks the accumulator as plain integer arithmetic modulo
//               2^ACC_W with a sticky flag for any wrap.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_mac_ctrl;

    localparam int WIDTH   = 4;
    localparam int ACC_W   = 12;
    localparam int MOD     = 1 << ACC_W;
    // out_valid rises after edge WIDTH*ACC_W (counted from the accepting
    // edge) and is therefore captured high at edge WIDTH*ACC_W+1
    localparam int LAT     = WIDTH * ACC_W;
    localparam int TIMEOUT = 200;

    logic             clk = 1'b0;
    logic             rst;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             clear;
    logic             busy;
    logic             out_valid;
    logic [ACC_W-1:0] acc_out;
    logic             overflow;

    int tests = 0;
    int fails = 0;
    int acc_m = 0;
    bit ovf_m = 1'b0;

    serial_mac_ctrl #(.WIDTH(WIDTH), .ACC_W(ACC_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .clear     (clear),
        .busy      (busy),
        .out_valid (out_valid),
        .acc_out   (acc_out),
        .overflow  (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input longint obs, input longint exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model_op(input int ta, input int tb_, input bit tclr);
        int s;
        if (tclr) begin
            acc_m = 0;
            ovf_m = 1'b0;
        end
        s = acc_m + ta * tb_;
        if (s >= MOD) ovf_m = 1'b1;
        acc_m = s % MOD;
    endtask

    // One full operation. hold=1 keeps in_valid high and scrambles a/b/clear
    // every cycle while busy; none of that may influence the result.
    task automatic run_op(input int ta, input int tb_, input bit tclr, input bit hold);
        int lat;
        int ready_bad;
        int prev_out;
        prev_out = acc_out;
        @(negedge clk);
        a        = WIDTH'(ta);
        b        = WIDTH'(tb_);
        clear    = tclr;
        in_valid = 1'b1;
        check("in_ready_before_accept", in_ready, 1);
        model_op(ta, tb_, tclr);
        tick();
        check("busy_after_accept", busy, 1);
        lat = 0;
        ready_bad = 0;
        while (!out_valid && lat < TIMEOUT) begin
            if (hold) begin
                a     = WIDTH'($urandom);
                b     = WIDTH'($urandom);
                clear = 1'($urandom_range(0, 1));
            end else begin
                in_valid = 1'b0;
                clear    = 1'b0;
                a        = WIDTH'($urandom);
                b        = WIDTH'($urandom);
            end
            if (in_ready !== 1'b0) ready_bad++;
            if (int'(acc_out) != (tclr ? 0 : prev_out)) ready_bad++;
            tick();
            lat++;
        end
        in_valid = 1'b0;
        clear    = 1'b0;
        check("latency", lat, LAT);
        check("in_ready_or_acc_out_moved_while_busy", ready_bad, 0);
        check("acc_out", acc_out, acc_m);
        check("overflow", overflow, ovf_m);
        tick();
        check("out_valid_one_cycle", out_valid, 0);
        check("in_ready_after_done", in_ready, 1);
        check("acc_out_hold", acc_out, acc_m);
    endtask

    task automatic clear_pulse();
        @(negedge clk);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        acc_m = 0;
        ovf_m = 1'b0;
        check("clear_acc_out", acc_out, 0);
        check("clear_overflow", overflow, 0);
        check("clear_no_busy", busy, 0);
    endtask

    initial begin
        int seen;
        rst      = 1'b1;
        in_valid = 1'b0;
        a        = '0;
        b        = '0;
        clear    = 1'b0;
        tick();
        tick();
        check("rst_busy", busy, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_acc_out", acc_out, 0);
        check("rst_overflow", overflow, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);

        // Scenario 1..3
        clear_pulse();
        run_op(3, 5, 0, 0);
        check("s1_acc", acc_out, 15);
        run_op(4, 4, 0, 0);
        check("s2_acc", acc_out, 31);
        run_op(0, 9, 0, 0);
        check("s2_zero_mult", acc_out, 31);
        run_op(2, 3, 1, 0);
        check("s3_clear_with_accept", acc_out, 6);
        check("s3_ovf", overflow, 0);

        // Scenario 4: 19 x (15*15) from cleared
        for (int i = 0; i < 19; i++) begin
            run_op(15, 15, (i == 0), 0);
            check("s4_ovf_step", overflow, (i == 18) ? 1 : 0);
        end
        check("s4_acc", acc_out, 179);
        clear_pulse();

        // Scenario 5: reset during ADD
        run_op(2, 2, 0, 0);
        @(negedge clk);
        a        = 4'd7;
        b        = 4'd7;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        for (int i = 0; i < 20; i++) tick();
        rst = 1'b1;
        #2;
        check("s5_rst_busy", busy, 0);
        check("s5_rst_acc_out", acc_out, 0);
        check("s5_rst_out_valid", out_valid, 0);
        @(negedge clk);
        rst   = 1'b0;
        acc_m = 0;
        ovf_m = 1'b0;
        seen  = 0;
        for (int i = 0; i < LAT + 4; i++) begin
            tick();
            if (out_valid) seen++;
        end
        check("s5_no_out_valid", seen, 0);
        run_op(1, 1, 0, 0);
        check("s5_acc", acc_out, 1);

        // Scenario 6: noisy inputs while busy
        run_op(5, 6, 0, 1);
        run_op(9, 3, 0, 1);

        // Randomized operations
        for (int i = 0; i < 30; i++) begin
            run_op(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)),
                   ($urandom_range(0, 5) == 0), bit'($urandom_range(0, 1)));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
